// File: rtl/counter_run_ctrl.sv
// Run sequencer for an external free-running counter.
// Clears the counter, enables it until it reaches the programmed target,
// pauses for HOLD_CYCLES, and repeats for the programmed number of runs.
// The host sees a start/busy/done handshake.
// Handshake: start is taken only in IDLE (and only when abort is low);
// busy is high in every other state; done pulses for one cycle on normal
// completion. abort drops cnt_en/cnt_clr in the same cycle and returns to
// IDLE without a done pulse.
module counter_run_ctrl #(
  parameter int WIDTH       = 4,
  parameter int REPS_W      = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WIDTH-1:0]  target,
  input  logic [REPS_W-1:0] reps,
  input  logic              abort,
  input  logic [WIDTH-1:0]  count,
  output logic              cnt_clr,
  output logic              cnt_en,
  output logic              busy,
  output logic              done,
  output logic [REPS_W-1:0] run_idx,
  output logic [2:0]        dbg_state
);

  // Hold gap counter only needs to reach HOLD_CYCLES-1.
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0]     HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0]     ONE_H     = HW'(1);
  localparam logic [REPS_W-1:0] ONE_R     = REPS_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_q,   state_d;
  logic [WIDTH-1:0]  target_q,  target_d;
  logic [REPS_W-1:0] reps_q,    reps_d;
  logic [REPS_W-1:0] run_idx_q, run_idx_d;
  logic [HW-1:0]     hold_q,    hold_d;

  assign run_idx   = run_idx_q;
  assign dbg_state = state_q;

  // State and latched sequence parameters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      target_q  <= '0;
      reps_q    <= '0;
      run_idx_q <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      reps_q    <= reps_d;
      run_idx_q <= run_idx_d;
      hold_q    <= hold_d;
    end
  end

  // Next-state and output decode; abort overrides every active state.
  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    reps_d    = reps_q;
    run_idx_d = run_idx_q;
    hold_d    = hold_q;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    done      = 1'b0;
    busy      = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          target_d  = target;
          reps_d    = (reps == '0) ? ONE_R : reps;
          run_idx_d = '0;
          hold_d    = '0;
          state_d   = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          cnt_clr = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          // Equality only: a disturbed counter above target wraps back round.
          cnt_en = (count != target_q);
          if (count == target_q) begin
            hold_d  = '0;
            state_d = ((run_idx_q + ONE_R) == reps_q) ? S_DONE : S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (hold_q == HOLD_LAST) begin
          run_idx_d = run_idx_q + ONE_R;
          state_d   = S_CLEAR;
        end else begin
          hold_d = hold_q + ONE_H;
        end
      end
      S_DONE: begin
        done    = !abort;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Bench for counter_run_ctrl with a behavioural counter attached.
module tb_counter_run_ctrl;

  localparam int WIDTH  = 4;
  localparam int REPS_W = 4;
  localparam int HOLD   = 2;
  localparam int EW     = 4 + REPS_W;

  // Clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [WIDTH-1:0]  target = '0;
  logic [REPS_W-1:0] reps = '0;
  logic [WIDTH-1:0]  count;
  logic              cnt_clr, cnt_en, busy, done;
  logic [REPS_W-1:0] run_idx;
  logic [2:0]        dbg_state;

  counter_run_ctrl #(.WIDTH(WIDTH), .REPS_W(REPS_W), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset(reset), .start(start), .target(target), .reps(reps),
    .abort(abort), .count(count), .cnt_clr(cnt_clr), .cnt_en(cnt_en),
    .busy(busy), .done(done), .run_idx(run_idx), .dbg_state(dbg_state)
  );

  // Behavioural external counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        count <= '0;
    else if (cnt_clr) count <= '0;
    else if (cnt_en)  count <= count + 1'b1;
  end

  // Scoreboard
  int n_vec = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: per-cycle {busy, clr, en, done, run_idx} trace of one sequence
  task automatic build_trace(input int t, input int r);
    int rr;
    rr = (r == 0) ? 1 : r;
    exp_q.delete();
    for (int ri = 0; ri < rr; ri++) begin
      exp_q.push_back({1'b1, 1'b1, 1'b0, 1'b0, REPS_W'(ri)});
      for (int i = 0; i < t; i++) exp_q.push_back({1'b1, 1'b0, 1'b1, 1'b0, REPS_W'(ri)});
      exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b0, REPS_W'(ri)});
      if (ri < rr - 1)
        for (int h = 0; h < HOLD; h++) exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b0, REPS_W'(ri)});
      else
        exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b1, REPS_W'(ri)});
    end
  endtask

  // Driver: one full sequence, optionally with start noise while busy
  task automatic run_seq(input int t, input int r, input bit noise,
                         output int n_busy, output int n_en, output int n_clr, output int n_done);
    logic [EW-1:0] e;
    int rr;
    rr = (r == 0) ? 1 : r;
    n_busy = 0; n_en = 0; n_clr = 0; n_done = 0;
    build_trace(t, r);
    @(negedge clk);
    start = 1'b1; target = WIDTH'(t); reps = REPS_W'(r);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      chk("trace", {busy, cnt_clr, cnt_en, done, run_idx}, e);
      n_busy += int'(busy); n_en += int'(cnt_en); n_clr += int'(cnt_clr); n_done += int'(done);
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise) begin
        target = WIDTH'($urandom_range(0, 15));
        reps   = REPS_W'($urandom_range(0, 15));
      end
    end
    @(negedge clk);
    chk("idle_after", {busy, cnt_clr, cnt_en, done, run_idx}, {4'b0000, REPS_W'(rr - 1)});
    chk("final_count", 32'(count), 32'(t));
    start = 1'b0;
  endtask

  typedef struct {
    int t; int r; bit noise;
    int busy_n; int en_n; int clr_n; int done_n;
  } vec_t;

  vec_t tbl[5];

  initial begin : main
    int nb, ne, nc, nd, dn, k;
    bit found;

    tbl[0] = '{t: 5,  r: 1, noise: 0, busy_n: 8,  en_n: 5,  clr_n: 1, done_n: 1};
    tbl[1] = '{t: 3,  r: 3, noise: 0, busy_n: 20, en_n: 9,  clr_n: 3, done_n: 1};
    tbl[2] = '{t: 0,  r: 0, noise: 0, busy_n: 3,  en_n: 0,  clr_n: 1, done_n: 1};
    tbl[3] = '{t: 15, r: 1, noise: 1, busy_n: 18, en_n: 15, clr_n: 1, done_n: 1};
    tbl[4] = '{t: 1,  r: 2, noise: 1, busy_n: 9,  en_n: 2,  clr_n: 2, done_n: 1};

    // Reset state
    #2;
    chk("reset_outs", {busy, cnt_clr, cnt_en, done, run_idx}, '0);
    chk("reset_state", 32'(dbg_state), 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", {busy, cnt_clr, cnt_en, done}, 4'b0000);

    // Table vectors
    foreach (tbl[i]) begin
      run_seq(tbl[i].t, tbl[i].r, tbl[i].noise, nb, ne, nc, nd);
      chk($sformatf("tbl%0d_busy", i), 32'(nb), 32'(tbl[i].busy_n));
      chk($sformatf("tbl%0d_en", i),   32'(ne), 32'(tbl[i].en_n));
      chk($sformatf("tbl%0d_clr", i),  32'(nc), 32'(tbl[i].clr_n));
      chk($sformatf("tbl%0d_done", i), 32'(nd), 32'(tbl[i].done_n));
    end

    // abort and start together in IDLE: abort wins
    @(negedge clk);
    start = 1'b1; abort = 1'b1; target = 4'd4; reps = 4'd1;
    @(negedge clk);
    chk("abort_start_idle", {busy, cnt_clr, cnt_en, done}, 4'b0000);
    start = 1'b0; abort = 1'b0;

    // Abort at count=2 of run 1 (target=7, reps=2)
    @(negedge clk);
    start = 1'b1; target = 4'd7; reps = 4'd2;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (k = 0; k < 60 && !found; k++) begin
      if (run_idx == 4'd1 && count == 4'd2 && busy) found = 1'b1;
      else @(negedge clk);
    end
    chk("abort_reach", 32'(found), 32'd1);
    abort = 1'b1;
    #1;
    chk("abort_same_cycle", {busy, cnt_clr, cnt_en, done}, 4'b1000);
    @(negedge clk);
    abort = 1'b0;
    chk("abort_idle", {busy, 3'(dbg_state)}, 4'b0000);
    dn = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      dn += int'(done) + int'(busy);
    end
    chk("abort_no_done", 32'(dn), 32'd0);
    chk("abort_count_held", 32'(count), 32'd2);

    // Reset mid-RUN at count=3 of run 1
    @(negedge clk);
    start = 1'b1; target = 4'd9; reps = 4'd2;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (k = 0; k < 60 && !found; k++) begin
      if (run_idx == 4'd1 && count == 4'd3 && cnt_en) found = 1'b1;
      else @(negedge clk);
    end
    chk("rst_reach", 32'(found), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_outs", {busy, cnt_clr, cnt_en, done, run_idx}, '0);
    chk("rst_mid_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_no_done", {busy, done}, 2'b00);
    run_seq(2, 1, 1'b0, nb, ne, nc, nd);
    chk("rst_restart_done", 32'(nd), 32'd1);

    // Randomized sequences against the reference trace
    for (int n = 0; n < 20; n++) begin
      run_seq($urandom_range(0, 15), $urandom_range(0, 5), 1'($urandom_range(0, 1)), nb, ne, nc, nd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
